// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loader_pkg
//  Purpose  : Shared types and constants for the instruction-memory loader.
//  Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Loader frame-parsing states
  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } loader_state_t;

  // Starting value of the running XOR checksum
  localparam logic [7:0] CHK_INIT = 8'h00;

  // Bytes that make up one instruction word
  localparam int BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : word_assembler
//  Purpose  : Collects big-endian bytes into 32-bit words. word_valid pulses
//             combinationally with the fourth byte of each word; word then
//             carries the complete word including that byte.
//  Revision : 1.0 - initial release
// ============================================================================
module word_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  // Only the first three bytes need storage; the fourth is taken straight
  // from byte_in so the word is available in the same cycle it completes.
  logic [1:0]  byte_cnt;
  logic [23:0] shift_reg;

  assign word_valid = load && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {shift_reg, byte_in};

  // Advance the byte counter and shift in each loaded byte, MSB first
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt  <= 2'd0;
      shift_reg <= 24'd0;
    end else if (load) begin
      byte_cnt  <= byte_cnt + 2'd1;
      shift_reg <= {shift_reg[15:0], byte_in};
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Receives a framed byte stream (length, data words, XOR checksum),
//             writes the words into instruction memory and releases the CPU
//             from hold once a frame with a good checksum has been loaded.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Memory capacity in words, widened so the 16-bit length compares safely
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  loader_state_t     state;
  loader_state_t     state_next;
  logic              accept;
  logic [7:0]        len_hi;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   idx_next;
  logic [7:0]        chk;
  logic              asm_load;
  logic              word_valid;
  logic [31:0]       asm_word;

  assign in_ready = !reset && ((state == S_LEN_HI) || (state == S_LEN_LO) ||
                               (state == S_DATA)   || (state == S_CHECK));
  assign accept   = in_valid && in_ready;
  assign len_full = {len_hi, in_data};
  assign idx_next = word_idx + (ADDR_W + 1)'(1);
  assign asm_load = accept && (state == S_DATA);

  word_assembler u_word_assembler (
    .clock      (clock),
    .reset      (reset),
    .load       (asm_load),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (asm_word)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_LEN_HI;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and status outputs
  always_comb begin
    state_next = state;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      S_LEN_HI: begin
        if (accept) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_full} > CAPACITY) begin
            state_next = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_valid && (idx_next == word_count)) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (accept) state_next = (in_data == chk) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        state_next = S_ERROR;
      end
    endcase
  end

  // Length capture, checksum accumulation, word index and write-port registers
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      chk        <= CHK_INIT;
      word_idx   <= '0;
      word_count <= '0;
      len_hi     <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_LEN_HI: len_hi <= in_data;
          S_LEN_LO: word_count <= len_full[ADDR_W:0];
          S_DATA: begin
            chk <= chk ^ in_data;
            if (word_valid) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx[ADDR_W-1:0];
              mem_wdata <= asm_word;
              word_idx  <= idx_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader: cycle-exact vector table for
//             a two-word frame plus directed frame sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int b2b    = 0;
  logic prev_we = 1'b0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic        hold;
  } vec_t;

  vec_t vecs[12];

  imem_loader #(.ADDR_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Capture every write and flag back-to-back write strobes
  always @(negedge clock) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (mem_we && prev_we) b2b <= b2b + 1;
    prev_we <= mem_we;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clock);
    #1 chk("ready_during_reset", in_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle_pct);
    bit ok = 0;
    int idle = 0;
    while (idle < 8 && $urandom_range(99) < idle_pct) begin
      @(negedge clock); in_valid = 1'b0; idle++;
    end
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock); in_valid = 1'b1; in_data = b;
      #1 if (in_ready) ok = 1;
    end
    if (ok) begin
      @(posedge clock);
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout: byte %h not accepted, in_ready %b expected 1", b, in_ready);
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int idle_pct);
    foreach (f[i]) send_byte(f[i], idle_pct);
    @(negedge clock); in_valid = 1'b0;
  endtask

  // Expected writes of the two-word frame
  task automatic check_two_writes(input string tag);
    chk({tag, "_nwrites"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_addr0"}, wr_addr[0], 8'h00);
      chk({tag, "_data0"}, wr_data[0], 32'h20080005);
      chk({tag, "_addr1"}, wr_addr[1], 8'h01);
      chk({tag, "_data1"}, wr_data[1], 32'h00000008);
    end
  endtask

  logic [7:0] frm[$];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;

    // Two-word frame, no gaps; XOR of the eight data bytes is 0x25.
    // The checksum byte arrives while the second write strobe is high.
    //            valid data   rdy we  addr   wdata          done err hold
    vecs[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 8'h20, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 8'h08, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 32'h20080005, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h20080005, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h20080005, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'h08, 1'b1, 1'b0, 8'h00, 32'h20080005, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'h25, 1'b1, 1'b1, 8'h01, 32'h00000008, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 32'h00000008, 1'b1, 1'b0, 1'b0};

    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      in_valid = vecs[k].valid; in_data = vecs[k].data;
      #1;
      chk($sformatf("v%0d_ready", k), in_ready,  vecs[k].ready);
      chk($sformatf("v%0d_we",    k), mem_we,    vecs[k].we);
      chk($sformatf("v%0d_addr",  k), mem_addr,  vecs[k].addr);
      chk($sformatf("v%0d_wdata", k), mem_wdata, vecs[k].wdata);
      chk($sformatf("v%0d_done",  k), done,      vecs[k].done);
      chk($sformatf("v%0d_error", k), error,     vecs[k].err);
      chk($sformatf("v%0d_hold",  k), cpu_hold,  vecs[k].hold);
    end
    @(negedge clock); in_valid = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_two_writes("table");
    chk("table_done_sticky", done, 1'b1);

    // Bad checksum: writes still happen, frame is rejected
    do_reset();
    frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08, 8'h24};
    send_frame(frm, 0);
    repeat (3) @(negedge clock);
    #1;
    check_two_writes("badchk");
    chk("badchk_error", error, 1'b1);
    chk("badchk_done", done, 1'b0);
    chk("badchk_hold", cpu_hold, 1'b1);
    chk("badchk_ready", in_ready, 1'b0);

    // Length 257 exceeds a 256-word memory
    do_reset();
    frm = '{8'h01, 8'h01};
    send_frame(frm, 0);
    #1;
    chk("over_error_next_cycle", error, 1'b1);
    chk("over_ready", in_ready, 1'b0);
    repeat (4) @(negedge clock);
    #1;
    chk("over_nwrites", wr_addr.size(), 0);

    // Empty frame with good and bad checksum
    do_reset();
    frm = '{8'h00, 8'h00, 8'h00};
    send_frame(frm, 0);
    #1;
    chk("empty_done", done, 1'b1);
    chk("empty_hold", cpu_hold, 1'b0);
    repeat (2) @(negedge clock);
    chk("empty_nwrites", wr_addr.size(), 0);

    do_reset();
    frm = '{8'h00, 8'h00, 8'hFF};
    send_frame(frm, 0);
    #1;
    chk("emptybad_error", error, 1'b1);
    chk("emptybad_done", done, 1'b0);

    // Two-word frame with random idle gaps
    do_reset();
    frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08, 8'h25};
    send_frame(frm, 40);
    repeat (3) @(negedge clock);
    #1;
    check_two_writes("gaps");
    chk("gaps_done", done, 1'b1);
    chk("gaps_hold", cpu_hold, 1'b0);

    // Reset after six bytes, then a fresh one-word frame
    do_reset();
    frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    foreach (frm[i]) send_byte(frm[i], 0);
    @(negedge clock);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    #1;
    chk("midrst_we", mem_we, 1'b0);
    chk("midrst_addr", mem_addr, 8'h00);
    chk("midrst_wdata", mem_wdata, 32'h0);
    chk("midrst_ready", in_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_frame(frm, 0);
    repeat (3) @(negedge clock);
    #1;
    chk("midrst_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("midrst_addr0", wr_addr[0], 8'h00);
      chk("midrst_data0", wr_data[0], 32'h12345678);
    end
    chk("midrst_done", done, 1'b1);

    chk("no_back_to_back_we", b2b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
